// File: rtl/wb_uart_lite_pkg.sv
// Shared constants and types for the Wishbone UART: register offsets,
// STATUS bit positions, engine state encodings and divisor helpers.
package wb_uart_lite_pkg;

    localparam int DIV_W = 24;

    // Register offsets, decoded from wbs_adr_i[3:2]
    localparam logic [1:0] ADR_SETUP  = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_RXDATA = 2'd2;
    localparam logic [1:0] ADR_TXDATA = 2'd3;

    // STATUS bit positions
    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_BUSY     = 2;
    localparam int ST_RX_OVERRUN  = 3;
    localparam int ST_FRAME_ERR   = 4;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // A divisor below 2 cannot produce a half-bit sample point
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(2)) ? DIV_W'(2) : d;
    endfunction

endpackage

// File: rtl/wb_uart_lite_fifo.sv
// Small synchronous show-ahead byte FIFO. Pop is ignored when empty; a push
// while full is accepted only if a pop frees a slot in the same cycle.
module uart_sync_fifo #(
    parameter int LGFLEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       empty,
    output logic       full
);

    localparam int DEPTH = 1 << LGFLEN;

    logic [7:0]        mem [DEPTH];
    logic [LGFLEN-1:0] wptr;
    logic [LGFLEN-1:0] rptr;
    logic [LGFLEN:0]   count;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (LGFLEN+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rptr];

    // Pointer and fill-level bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + LGFLEN'(1);
            if (do_pop)  rptr <= rptr + LGFLEN'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (LGFLEN+1)'(1);
                2'b01:   count <= count - (LGFLEN+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/wb_uart_lite.sv
// Wishbone-slave 8N1 UART with a programmable divisor and TX/RX FIFOs.
module wb_uart_lite
    import wb_uart_lite_pkg::*;
#(
    parameter logic [DIV_W-1:0] INITIAL_SETUP = 24'd434,
    parameter int               LGFLEN        = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    output logic        o_rx_int,
    output logic        o_tx_int
);

    // ---------------- bus decode ----------------
    logic [1:0]       adr;
    logic             req, wr, rd;
    logic [DIV_W-1:0] setup;
    logic             rx_overrun, frame_err;
    logic [31:0]      rd_word;
    logic [31:0]      status_word;

    logic       tx_push, tx_pop, tx_empty, tx_full;
    logic [7:0] tx_q;
    logic       rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0] rx_q;

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:24], wbs_sel_i[3]};

    assign adr     = wbs_adr_i[3:2];
    assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr      = req & wbs_we_i;
    assign rd      = req & ~wbs_we_i;
    assign tx_push = wr & (adr == ADR_TXDATA) & wbs_sel_i[0];
    assign rx_pop  = rd & (adr == ADR_RXDATA);

    // ---------------- TX engine signals ----------------
    tx_state_t        tx_state, tx_state_n;
    logic [DIV_W-1:0] tx_div, tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_line, tx_bit_end, tx_load, tx_busy;

    // ---------------- RX engine signals ----------------
    rx_state_t        rx_state, rx_state_n;
    logic [DIV_W-1:0] rx_div, rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_s1, rx_s2, rx_prev;
    logic             rx_fall, rx_half_end, rx_bit_end, rx_stop_done;
    logic             rx_fe_set, rx_ovr_set;

    uart_sync_fifo #(.LGFLEN(LGFLEN)) u_tx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(tx_push), .push_data(wbs_dat_i[7:0]),
        .pop(tx_pop), .pop_data(tx_q), .empty(tx_empty), .full(tx_full)
    );

    uart_sync_fifo #(.LGFLEN(LGFLEN)) u_rx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(rx_push), .push_data(rx_shift),
        .pop(rx_pop), .pop_data(rx_q), .empty(rx_empty), .full(rx_full)
    );

    // Gather STATUS bits
    always_comb begin
        status_word                 = '0;
        status_word[ST_RX_NONEMPTY] = ~rx_empty;
        status_word[ST_TX_FULL]     = tx_full;
        status_word[ST_TX_BUSY]     = tx_busy;
        status_word[ST_RX_OVERRUN]  = rx_overrun;
        status_word[ST_FRAME_ERR]   = frame_err;
    end

    // Read-data multiplexer
    always_comb begin
        rd_word = '0;
        case (adr)
            ADR_SETUP:  rd_word = {8'h00, setup};
            ADR_STATUS: rd_word = status_word;
            ADR_RXDATA: rd_word = {23'b0, rx_empty, (rx_empty ? 8'h00 : rx_q)};
            default:    rd_word = {31'b0, tx_full};
        endcase
    end

    // Single-cycle ack with registered read data
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req;
            if (req) wbs_dat_o <= rd_word;
        end
    end

    // SETUP register with per-byte write enables
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            setup <= INITIAL_SETUP;
        end else if (wr && adr == ADR_SETUP) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (wbs_sel_i[i]) setup[8*i +: 8] <= wbs_dat_i[8*i +: 8];
            end
        end
    end

    // Sticky error flags: write-1-to-clear, a same-cycle set takes priority
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_overrun <= rx_ovr_set | (rx_overrun &
                          ~(wr && adr == ADR_STATUS && wbs_dat_i[ST_RX_OVERRUN]));
            frame_err  <= rx_fe_set  | (frame_err &
                          ~(wr && adr == ADR_STATUS && wbs_dat_i[ST_FRAME_ERR]));
        end
    end

    // ================= TX engine =================
    assign tx_bit_end = (tx_cnt == tx_div - DIV_W'(1));

    // TX state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) tx_state <= TX_IDLE;
        else          tx_state <= tx_state_n;
    end

    // TX next state; a stop bit with more data queued chains straight into a start bit
    always_comb begin
        tx_state_n = tx_state;
        case (tx_state)
            TX_IDLE:  if (!tx_empty) tx_state_n = TX_START;
            TX_START: if (tx_bit_end) tx_state_n = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_state_n = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_state_n = tx_empty ? TX_IDLE : TX_START;
            default:  tx_state_n = TX_IDLE;
        endcase
    end

    // TX control outputs: frame load/pop and busy indication
    always_comb begin
        tx_load = ~tx_empty & ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_bit_end));
        tx_pop  = tx_load;
        tx_busy = (tx_state != TX_IDLE) | ~tx_empty;
    end

    // TX datapath: bit timer, shifter and registered line driver
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tx_div   <= INITIAL_SETUP;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else if (tx_load) begin
            tx_div   <= clamp_div(setup);
            tx_shift <= tx_q;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_line  <= 1'b0;
        end else if (tx_state != TX_IDLE) begin
            if (tx_bit_end) begin
                tx_cnt <= '0;
                case (tx_state)
                    TX_START: tx_line <= tx_shift[0];
                    TX_DATA: begin
                        if (tx_bit == 3'd7) begin
                            tx_line <= 1'b1;
                        end else begin
                            tx_line  <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end
                    default: tx_line <= 1'b1;
                endcase
            end else begin
                tx_cnt <= tx_cnt + DIV_W'(1);
            end
        end
    end

    assign o_uart_tx = tx_line;

    // ================= RX engine =================
    // Two-flop synchronizer plus a delayed copy for edge detection
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= i_uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall     = rx_prev & ~rx_s2;
    assign rx_half_end = (rx_cnt == (rx_div >> 1) - DIV_W'(1));
    assign rx_bit_end  = (rx_cnt == rx_div - DIV_W'(1));

    // RX state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) rx_state <= RX_IDLE;
        else          rx_state <= rx_state_n;
    end

    // RX next state; a high start re-sample is treated as a glitch
    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_n = RX_START;
            RX_START: if (rx_half_end) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_state_n = RX_STOP;
            RX_STOP:  if (rx_bit_end) rx_state_n = RX_IDLE;
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    // RX outputs: push on a good stop bit, raise error flags otherwise
    always_comb begin
        rx_stop_done = (rx_state == RX_STOP) & rx_bit_end;
        rx_push      = rx_stop_done & rx_s2;
        rx_fe_set    = rx_stop_done & ~rx_s2;
        rx_ovr_set   = rx_push & rx_full & ~rx_pop;
    end

    // RX datapath: bit timer and LSB-first shifter
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_div   <= INITIAL_SETUP;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall) begin
                        rx_div <= clamp_div(setup);
                        rx_cnt <= '0;
                        rx_bit <= '0;
                    end
                end
                RX_START: rx_cnt <= rx_half_end ? '0 : rx_cnt + DIV_W'(1);
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + DIV_W'(1);
                    end
                end
                default: rx_cnt <= rx_bit_end ? '0 : rx_cnt + DIV_W'(1);
            endcase
        end
    end

    assign o_rx_int = ~rx_empty;
    assign o_tx_int = ~tx_full;

endmodule

// File: tb/tb_wb_uart_lite.sv
// Randomized self-checking bench for wb_uart_lite: a line-level TX decoder and
// an RX byte/flag model (queue of at most four bytes) supply all expectations.
module tb_wb_uart_lite;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        i_uart_rx = 1'b1;
    logic        o_uart_tx, o_rx_int, o_tx_int;

    wb_uart_lite #(.INITIAL_SETUP(24'd434), .LGFLEN(2)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .i_uart_rx(i_uart_rx), .o_uart_tx(o_uart_tx),
        .o_rx_int(o_rx_int), .o_tx_int(o_tx_int)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc_cnt = 0;
    int          cur_div = 434;

    logic [9:0]  tx_seen[$];   // {start, stop, data} as decoded from the line
    int unsigned tx_t0[$];
    logic [7:0]  tx_exp[$];
    logic [7:0]  rx_model[$];
    bit          ovr_m = 0, fe_m = 0;

    always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Passive line decoder: samples each bit at its centre
    initial begin : tx_monitor
        logic [7:0] b;
        logic       st, sp;
        int         d;
        int unsigned t0;
        forever begin
            @(negedge o_uart_tx);
            t0 = cyc_cnt;
            d  = cur_div;
            repeat (d / 2) @(negedge wb_clk_i);
            st = o_uart_tx;
            for (int i = 0; i < 8; i++) begin
                repeat (d) @(negedge wb_clk_i);
                b[i] = o_uart_tx;
            end
            repeat (d) @(negedge wb_clk_i);
            sp = o_uart_tx;
            tx_seen.push_back({st, sp, b});
            tx_t0.push_back(t0);
        end
    end

    task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = {28'b0, a, 2'b00}; wbs_dat_i = dat; wbs_sel_i = sel;
        @(posedge wb_clk_i); #1;
        check("ack_pulse", {31'b0, wbs_ack_o}, 32'd1);
        rdat = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        @(posedge wb_clk_i); #1;
        check("ack_single", {31'b0, wbs_ack_o}, 32'd0);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] unused_r;
        wb_xfer(1'b1, a, dat, sel, unused_r);
    endtask

    task automatic check_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, a, 32'h0, 4'hF, r);
        check(tag, r, exp);
    endtask

    function automatic logic [31:0] status_exp();
        return {27'b0, fe_m, ovr_m, 1'b0, 1'b0, rx_model.size() != 0};
    endfunction

    task automatic rx_read_check(input string tag);
        logic [31:0] exp;
        exp = (rx_model.size() != 0) ? {24'b0, rx_model.pop_front()} : 32'h100;
        check_read(tag, 2'd2, exp);
    endtask

    // Drive one 8N1 frame on the RX line and update the byte/flag model
    task automatic send_rx(input logic [7:0] b, input bit stop_ok);
        int d = cur_div;
        i_uart_rx = 1'b0;
        repeat (d) @(posedge wb_clk_i); #1;
        for (int i = 0; i < 8; i++) begin
            i_uart_rx = b[i];
            repeat (d) @(posedge wb_clk_i); #1;
        end
        i_uart_rx = stop_ok;
        repeat (d) @(posedge wb_clk_i); #1;
        if (!stop_ok) begin
            i_uart_rx = 1'b1;
            repeat (d) @(posedge wb_clk_i); #1;
            fe_m = 1;
        end else if (rx_model.size() < 4) begin
            rx_model.push_back(b);
        end else begin
            ovr_m = 1;
        end
    endtask

    task automatic wait_tx_idle();
        logic [31:0] r;
        int n = 0;
        do begin
            wb_xfer(1'b0, 2'd1, 32'h0, 4'hF, r);
            n++;
        end while (r[2] && n < 6000);
        check("tx_idle", {31'b0, r[2]}, 32'd0);
        repeat (2) @(posedge wb_clk_i); #1;
    endtask

    task automatic check_tx_frames();
        logic [7:0]  e;
        logic [31:0] got;
        while (tx_exp.size() != 0) begin
            e   = tx_exp.pop_front();
            got = (tx_seen.size() != 0) ? {22'b0, tx_seen.pop_front()} : '1;
            check("tx_frame", got, {22'b0, 2'b01, e});
        end
        check("tx_extra", tx_seen.size(), 0);
    endtask

    task automatic set_div(input int d);
        wb_write(2'd0, d, 4'hF);
        cur_div = d;
    endtask

    initial begin : main
        logic [9:0]  frame;
        logic [7:0]  b;
        logic [31:0] r, wd;
        logic [23:0] setup_m;
        string       s;
        int          n, errs;

        repeat (3) @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;

        // Reset state
        check("rst_tx", {31'b0, o_uart_tx}, 32'd1);
        check("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_rxint", {31'b0, o_rx_int}, 32'd0);
        check("rst_txint", {31'b0, o_tx_int}, 32'd1);
        check_read("rst_setup", 2'd0, 32'h1B2);
        check_read("rst_status", 2'd1, 32'h0);

        // Exact waveform of one 0x55 frame at divisor 434
        wb_write(2'd3, 32'h55, 4'h1);
        @(negedge wb_clk_i);
        n = 0;
        while (o_uart_tx !== 1'b0 && n < 8) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("tx55_start", {31'b0, (n < 8)}, 32'd1);
        frame = {1'b1, 8'h55, 1'b0};
        errs = 0;
        for (int k = 0; k < 4340; k++) begin
            if (o_uart_tx !== frame[k / 434]) errs++;
            @(negedge wb_clk_i);
        end
        check("tx55_wave", errs, 0);
        repeat (2) @(posedge wb_clk_i); #1;
        check_read("tx55_busy_done", 2'd1, 32'h0);
        tx_exp.push_back(8'h55);
        check_tx_frames();

        // Short low glitch on RX is rejected
        i_uart_rx = 1'b0;
        repeat (100) @(posedge wb_clk_i); #1;
        i_uart_rx = 1'b1;
        repeat (600) @(posedge wb_clk_i); #1;
        check_read("glitch_status", 2'd1, status_exp());
        rx_read_check("glitch_rx");

        // Host string at 115200 baud, echoed back by firmware
        s = "de 1b2";
        for (int i = 0; i < s.len(); i++) begin
            send_rx(s[i], 1'b1);
            check("echo_rxint", {31'b0, o_rx_int}, 32'd1);
            wb_xfer(1'b0, 2'd2, 32'h0, 4'hF, r);
            check("echo_rx", r, {24'b0, rx_model.pop_front()});
            wb_write(2'd3, {24'b0, r[7:0]}, 4'h1);
            tx_exp.push_back(s[i]);
        end
        wait_tx_idle();
        check_tx_frames();

        // Overrun: five bytes into a four-entry FIFO
        set_div(16);
        check_read("setup16", 2'd0, 32'd16);
        for (int i = 0; i < 5; i++) send_rx(8'($urandom), 1'b1);
        check_read("ovr_status", 2'd1, status_exp());
        for (int i = 0; i < 5; i++) rx_read_check("ovr_rx");
        wb_write(2'd1, 32'h8, 4'hF);
        ovr_m = 0;
        check_read("ovr_clear", 2'd1, status_exp());

        // Bad stop bit
        send_rx(8'($urandom), 1'b0);
        check_read("fe_status", 2'd1, status_exp());
        rx_read_check("fe_rx");
        wb_write(2'd1, 32'h10, 4'hF);
        fe_m = 0;
        check_read("fe_clear", 2'd1, status_exp());

        // Random divisors, full-duplex traffic, random stop-bit corruption
        for (int i = 0; i < 6; i++) begin
            set_div($urandom_range(12, 40));
            b = 8'($urandom);
            wb_write(2'd3, {24'b0, b}, 4'h1);
            tx_exp.push_back(b);
            send_rx(8'($urandom), $urandom_range(0, 3) != 0);
            wait_tx_idle();
            check_read("rnd_status", 2'd1, status_exp());
            rx_read_check("rnd_rx");
            if (fe_m) begin
                wb_write(2'd1, 32'h10, 4'hF);
                fe_m = 0;
            end
            check_tx_frames();
        end

        // Six back-to-back TX writes: five contiguous frames, sixth dropped
        set_div(16);
        tx_t0.delete();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            wb_write(2'd3, {24'b0, b}, 4'h1);
            if (i < 5) tx_exp.push_back(b);
        end
        check_read("burst_full", 2'd3, 32'd1);
        check("burst_txint", {31'b0, o_tx_int}, 32'd0);
        wait_tx_idle();
        check("burst_count", tx_t0.size(), 5);
        for (int i = 1; i < tx_t0.size(); i++) check("burst_gap", tx_t0[i] - tx_t0[i-1], 160);
        check_tx_frames();
        check("burst_txint_idle", {31'b0, o_tx_int}, 32'd1);

        // Byte-lane writes to SETUP
        setup_m = 24'd16;
        wd = $urandom;
        wb_write(2'd0, wd, 4'b0001);
        setup_m[7:0] = wd[7:0];
        check_read("sel0001", 2'd0, {8'b0, setup_m});
        wd = $urandom;
        wb_write(2'd0, wd, 4'b1110);
        setup_m[23:8] = wd[23:8];
        check_read("sel1110", 2'd0, {8'b0, setup_m});

        // Divisor 0 reads back as written but runs at 2 clocks per bit
        set_div(0);
        check_read("setup0", 2'd0, 32'd0);
        cur_div = 2;
        b = 8'($urandom);
        wb_write(2'd3, {24'b0, b}, 4'h1);
        tx_exp.push_back(b);
        wait_tx_idle();
        check_tx_frames();

        // SETUP change mid-frame leaves the running frame untouched
        set_div(16);
        b = 8'($urandom);
        wb_write(2'd3, {24'b0, b}, 4'h1);
        tx_exp.push_back(b);
        repeat (30) @(posedge wb_clk_i); #1;
        wb_write(2'd0, 32'd40, 4'hF);
        wait_tx_idle();
        check_tx_frames();
        set_div(16);

        // Reset mid-frame forces the line high at once
        wb_write(2'd3, 32'hA5, 4'h1);
        repeat (40) @(posedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        #1 check("rst_mid_tx", {31'b0, o_uart_tx}, 32'd1);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        repeat (300) @(posedge wb_clk_i); #1;
        check_read("rst_mid_setup", 2'd0, 32'h1B2);
        check_read("rst_mid_status", 2'd1, 32'h0);
        check("rst_mid_line", {31'b0, o_uart_tx}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_uart_lite.md
Name: wb_uart_lite

Overview:
- Wishbone-slave 8N1 UART with a programmable baud divisor and small TX/RX FIFOs.
- Sits in the user project area behind the management-core Wishbone bus. o_uart_tx/i_uart_rx route to mprj_io pads (RX on mprj_io[15]).
- Firmware echoes host bytes through it.
- Default divisor 434 gives 115200 baud at 50 MHz.

Parameters:
- INITIAL_SETUP, 24'd434: reset value of the baud divisor, in clocks per bit.
- LGFLEN, 2: log2 of the depth of each FIFO (4 entries).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  address; only [3:2] is decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- i_uart_rx  in  1  serial input, asynchronous, idle high.
- o_uart_tx  out  1  serial output, idle high.
- o_rx_int  out  1  high while the RX FIFO is not empty.
- o_tx_int  out  1  high while the TX FIFO is not full.

Behaviour:
- Reset values:
  - o_uart_tx=1, wbs_ack_o=0, wbs_dat_o=0.
  - Both FIFOs empty; sticky flags 0; SETUP=INITIAL_SETUP.
  - TX and RX engines IDLE.
- Bus protocol:
  - Classic Wishbone; a transaction is cyc&stb&!ack.
  - wbs_ack_o pulses for exactly 1 cycle, the cycle after the request; wbs_dat_o is valid in that cycle.
  - Every address is acked; no stalls, no errors.
- Register map (adr[3:2]):
  - 0 SETUP, RW: [23:0] divisor; [31:24] read 0. Writes honour wbs_sel_i[2:0]. An effective divisor <2 is clamped to 2.
  - 1 STATUS: [0] rx_nonempty, [1] tx_full, [2] tx_busy (engine active or FIFO nonempty), [3] rx_overrun (sticky), [4] frame_err (sticky). Writing 1 to bit 3 or 4 clears that bit; other bits read-only.
  - 2 RXDATA: read returns {23'b0, empty, data[7:0]} and pops when nonempty. Reading when empty returns bit8=1, data 0, no pop. Writes ignored.
  - 3 TXDATA: write with sel[0] pushes data[7:0]; dropped silently if full. Read returns {31'b0, tx_full}.
- FIFOs: synchronous; simultaneous push and pop are legal at any fill level, including full (pop frees space) and empty (no pop occurs).
- TX engine: IDLE→START→DATA(8, LSB first)→STOP→IDLE.
  - Leaves IDLE when the FIFO is nonempty: pops 1 byte and latches the divisor for the whole frame.
  - Each bit lasts exactly divisor clocks; frame = 10×divisor clocks.
  - Back-to-back frames have no extra idle.
  - o_uart_tx is registered, glitch-free.
- RX engine: 2-flop synchronizer on i_uart_rx; states IDLE→START→DATA→STOP.
  - Falling edge in IDLE starts a frame and latches the divisor.
  - Start is re-sampled at divisor/2; if high, it is a glitch → IDLE.
  - Data bits sampled every divisor clocks thereafter (bit centres), LSB first.
  - Stop sampled at its centre:
    - low → frame_err=1, byte discarded;
    - high → byte pushed, or rx_overrun=1 and byte dropped if the FIFO is full.
  - After the stop sample, returns to IDLE at once, so a start bit right after stop is caught.
- A SETUP write mid-frame does not affect the current frame in either engine.
- Reset asserted mid-frame aborts immediately: o_uart_tx=1, all state cleared.
- Sticky flag set and clear in the same cycle: set wins.

Decomposition:
- Package wb_uart_lite_pkg: register-offset constants, STATUS bit indices, TX/RX state enums, DIV_W=24.
- One sub-module, uart_sync_fifo (8-bit, depth 2**LGFLEN), instantiated for TX and RX.
- Engines and register decode stay inline.

Test Plan:
- Reset: read SETUP → 0x1B2 (434). Read STATUS → 0x0. o_uart_tx=1.
- Write TXDATA 0x55 → o_uart_tx low 434 clocks, then 1,0,1,0,1,0,1,0 at 434 clocks each, then high 434 clocks. STATUS[2] falls after 4340 clocks.
- Drive 115200-baud frames "de 1b2" on i_uart_rx → RXDATA reads return 0x64,0x65,0x20,0x31,0x62,0x32 in order. Firmware echo reproduces the same bytes on o_uart_tx.
- Write SETUP=16, then send 5 RX bytes without reading → first 4 read back intact, STATUS[3]=1. Write STATUS 0x8 → bit 3 cleared.
- RX low pulse of 100 clocks (<217) → no byte, no flags. Frame with stop bit low → frame_err=1, FIFO empty.
- Write TXDATA ×6 back-to-back → 5 frames contiguous on the line (one entry leaves the FIFO as the engine pops the first byte), sixth write dropped. Every ack is 1 cycle. SETUP write with sel=4'b0001 changes only [7:0].
